// File: rtl/passive_security_fsm_if.sv
// Vehicle status signs in, chime/siren/state out, between the stimulus
// generator (master) and the passive security controller (slave).
interface passive_security_fsm_if;
    logic       CarLightsOnSign;
    logic       OpenDoorSign;
    logic       IgnitionSignalOn;
    logic       PassiveSignal_b;
    logic       PassiveSignal_s;
    logic [2:0] SecState;

    modport master (
        output CarLightsOnSign,
        output OpenDoorSign,
        output IgnitionSignalOn,
        input  PassiveSignal_b,
        input  PassiveSignal_s,
        input  SecState
    );

    modport slave (
        input  CarLightsOnSign,
        input  OpenDoorSign,
        input  IgnitionSignalOn,
        output PassiveSignal_b,
        output PassiveSignal_s,
        output SecState
    );
endinterface

// File: rtl/passive_security_fsm.sv
// Passive car-security controller: debounces lights/door/ignition and runs the
// arm/entry/alarm state machine driving the chime and siren.
module passive_security_fsm #(
    parameter int DEB_CYCLES   = 2,
    parameter int ARM_DELAY    = 8,
    parameter int ENTRY_DELAY  = 6,
    parameter int ALARM_CYCLES = 16,
    parameter int CHIME_HALF   = 2,
    parameter int TW           = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    passive_security_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } secState_t;

    localparam int LIGHTS = 0;
    localparam int DOOR   = 1;
    localparam int IGN    = 2;

    localparam logic [TW-1:0] DEB_LAST   = TW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] ARM_LAST   = TW'(ARM_DELAY - 1);
    localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_DELAY - 1);
    localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_CYCLES - 1);
    localparam logic [TW-1:0] CHIME_LAST = TW'(CHIME_HALF - 1);

    logic [2:0]    rawSign;
    logic [2:0]    filtSign;
    logic [2:0]    filtNext;
    logic [TW-1:0] debCnt     [3];
    logic [TW-1:0] debCntNext [3];

    secState_t     state;
    secState_t     nextState;
    logic [TW-1:0] timer;
    logic [TW-1:0] timerNext;

    logic          chimePhase;
    logic          phaseNext;
    logic [TW-1:0] chimeCnt;
    logic [TW-1:0] chimeCntNext;
    logic          chimeOn;
    logic          chimeCondNext;
    logic          bReg;
    logic          sReg;
    logic          bNext;
    logic          sNext;

    assign rawSign = {bus.IgnitionSignalOn, bus.OpenDoorSign, bus.CarLightsOnSign};

    // Filtered bit flips only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filtNext[i]   = filtSign[i];
            debCntNext[i] = '0;
            if (rawSign[i] != filtSign[i]) begin
                if (debCnt[i] == DEB_LAST) begin
                    filtNext[i] = rawSign[i];
                end else begin
                    debCntNext[i] = debCnt[i] + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filtSign <= '0;
            debCnt   <= '{default: '0};
        end else begin
            filtSign <= filtNext;
            debCnt   <= debCntNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DISARMED;
            timer      <= '0;
            chimePhase <= 1'b0;
            chimeCnt   <= '0;
            bReg       <= 1'b0;
            sReg       <= 1'b0;
        end else begin
            state      <= nextState;
            timer      <= timerNext;
            chimePhase <= phaseNext;
            chimeCnt   <= chimeCntNext;
            bReg       <= bNext;
            sReg       <= sNext;
        end
    end

    // Abort/ignition checks come first so they beat a coincident timeout.
    always_comb begin
        nextState = state;
        case (state)
            DISARMED: if (!filtSign[IGN] && !filtSign[DOOR]) nextState = ARMING;
            ARMING: begin
                if (filtSign[IGN] || filtSign[DOOR]) nextState = DISARMED;
                else if (timer == ARM_LAST)          nextState = ARMED;
            end
            ARMED: begin
                if (filtSign[DOOR])     nextState = ENTRY;
                else if (filtSign[IGN]) nextState = ALARM;
            end
            ENTRY: begin
                if (filtSign[IGN])             nextState = DISARMED;
                else if (timer == ENTRY_LAST)  nextState = ALARM;
            end
            ALARM:   if (timer == ALARM_LAST) nextState = ARMED;
            default: nextState = DISARMED;
        endcase
        timerNext = (nextState != state) ? '0 : timer + TW'(1);
    end

    // Outputs are computed from post-edge values so they line up with SecState.
    always_comb begin
        chimeOn       = (state == DISARMED) && filtSign[DOOR]
                        && (filtSign[IGN] || filtSign[LIGHTS]);
        chimeCondNext = (nextState == DISARMED) && filtNext[DOOR]
                        && (filtNext[IGN] || filtNext[LIGHTS]);
        phaseNext     = 1'b0;
        chimeCntNext  = '0;
        if (chimeCondNext && chimeOn) begin
            if (chimeCnt == CHIME_LAST) begin
                phaseNext = ~chimePhase;
            end else begin
                phaseNext    = chimePhase;
                chimeCntNext = chimeCnt + TW'(1);
            end
        end
        bNext = (nextState == ENTRY) || (chimeCondNext && phaseNext);
        sNext = (nextState == ALARM);
    end

    assign bus.PassiveSignal_b = bReg;
    assign bus.PassiveSignal_s = sReg;
    assign bus.SecState        = state;

endmodule

// File: tb/tb_passive_security_fsm.sv
// Directed-vector bench: each stimulus cycle queues its expected outputs and a
// separate monitor compares them one cycle later on the falling edge.
module tb_passive_security_fsm;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    passive_security_fsm_if bus ();

    passive_security_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int         step;
        logic [2:0] st;
        logic       b;
        logic       s;
    } expect_t;

    expect_t expQ[$];
    int      checks = 0;
    int      errors = 0;
    int      stepNo = 0;

    // Drive one cycle of inputs and queue what the outputs must show after that edge.
    task automatic applyStimulus(input int rst, input int l, input int d, input int i,
                                 input int st, input int b, input int s);
        expect_t e;
        @(negedge clk);
        reset                = (rst != 0);
        bus.CarLightsOnSign  = (l != 0);
        bus.OpenDoorSign     = (d != 0);
        bus.IgnitionSignalOn = (i != 0);
        @(posedge clk);
        stepNo++;
        e.step = stepNo;
        e.st   = 3'(st);
        e.b    = (b != 0);
        e.s    = (s != 0);
        expQ.push_back(e);
    endtask

    task automatic applyRepeat(input int n, input int rst, input int l, input int d,
                               input int i, input int st, input int b, input int s);
        for (int k = 0; k < n; k++) applyStimulus(rst, l, d, i, st, b, s);
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if (bus.SecState !== e.st || bus.PassiveSignal_b !== e.b || bus.PassiveSignal_s !== e.s) begin
            errors++;
            $display("[TB] FAIL step%0d: got state=%0d b=%b s=%b, expected state=%0d b=%b s=%b",
                     e.step, bus.SecState, bus.PassiveSignal_b, bus.PassiveSignal_s,
                     e.st, e.b, e.s);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset                = 1'b1;
        bus.CarLightsOnSign  = 1'b0;
        bus.OpenDoorSign     = 1'b0;
        bus.IgnitionSignalOn = 1'b0;

        // Reset then arm: ARMING from edge 1, ARMED at edge 9
        applyRepeat(2, 1, 0, 0, 0, 0, 0, 0);
        applyRepeat(8, 0, 0, 0, 0, 1, 0, 0);
        applyRepeat(2, 0, 0, 0, 0, 2, 0, 0);

        // One-cycle door glitch is rejected
        applyStimulus(0, 0, 1, 0, 2, 0, 0);
        applyRepeat(2, 0, 0, 0, 0, 2, 0, 0);

        // Door held: ENTRY and chime on two edges after the rise
        applyRepeat(2, 0, 0, 1, 0, 2, 0, 0);
        applyStimulus(0, 0, 1, 0, 3, 1, 0);
        applyStimulus(0, 0, 0, 0, 3, 1, 0);

        // Ignition two cycles into ENTRY disarms after debounce
        applyRepeat(2, 0, 0, 0, 1, 3, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        // Drop ignition and re-arm
        applyRepeat(2, 0, 0, 0, 0, 0, 0, 0);
        applyRepeat(8, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 2, 0, 0);

        // Entry without ignition times out into ALARM after 6 cycles
        applyRepeat(2, 0, 0, 1, 0, 2, 0, 0);
        applyStimulus(0, 0, 1, 0, 3, 1, 0);
        applyRepeat(5, 0, 0, 0, 0, 3, 1, 0);
        applyStimulus(0, 0, 0, 0, 4, 0, 1);

        // 16 siren cycles; ignition raised late is ignored until exit, then tamper
        applyRepeat(9, 0, 0, 0, 0, 4, 0, 1);
        applyRepeat(6, 0, 0, 0, 1, 4, 0, 1);
        applyStimulus(0, 0, 0, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 1, 4, 0, 1);

        // Reset on alarm cycle 5 clears everything, then normal re-arm
        applyRepeat(3, 0, 0, 0, 1, 4, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyRepeat(8, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 2, 0, 0);

        // Chime: door+lights abort ARMING back to DISARMED, then b = 0,0,1,1,0,0,1
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyRepeat(2, 0, 1, 1, 0, 1, 0, 0);
        applyRepeat(2, 0, 1, 1, 0, 0, 0, 0);
        applyRepeat(2, 0, 1, 1, 0, 0, 1, 0);
        applyRepeat(2, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 0);

        // Door dropped: b low after debounce, then ARMING
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyRepeat(8, 0, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 2, 0, 0);

        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
